dsp_mac_seq: RTL



---
 rtl/dsp_seq_pkg.sv | 25 ++
 rtl/mac_tap_counter.sv | 58 +++++
 rtl/dsp_mac_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared definitions for the DSP MAC sequencer.
//   - state_t       : sequencer FSM states (3-bit encoding)
//   - DEF_*         : default datapath widths, matching the DSP/RAM primitives
//   - DSP_LAT_*     : legal range of the MAC pipeline latency, and the width
//                     of the drain counter that covers it
package dsp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_RES_W   = 64;
  localparam int DEF_DSP_LAT = 2;

  localparam int DSP_LAT_MIN = 1;
  localparam int DSP_LAT_MAX = 7;
  localparam int DSP_LAT_W   = 3;  // wide enough to hold DSP_LAT_MAX

endpackage : dsp_seq_pkg

// File: rtl/mac_tap_counter.sv
// Tap and drain counters for the MAC sequencer.
//   clk, rst_n    : clock, synchronous active-low reset
//   tap_load      : zero the tap index and latch tap_limit_in
//   tap_limit_in  : number of taps in the dot product
//   tap_inc       : one tap issued (operand beat accepted)
//   tap_index     : taps issued so far; also the coefficient offset
//   tap_last      : the current index is the final tap
//   drain_load    : load the drain counter with DSP_LAT
//   drain_dec     : count the drain down by one
//   drain_last    : final drain cycle; MAC_OUT is valid now
module mac_tap_counter
  import dsp_seq_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DSP_LAT = DEF_DSP_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tap_load,
  input  logic [ADDR_W-1:0] tap_limit_in,
  input  logic              tap_inc,
  output logic [ADDR_W-1:0] tap_index,
  output logic              tap_last,
  input  logic              drain_load,
  input  logic              drain_dec,
  output logic              drain_last
);

  logic [ADDR_W-1:0]    tap_limit;
  logic [DSP_LAT_W-1:0] drain_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap_index <= '0;
      tap_limit <= '0;
      drain_cnt <= '0;
    end else begin
      if (tap_load) begin
        tap_index <= '0;
        tap_limit <= tap_limit_in;
      end else if (tap_inc) begin
        tap_index <= tap_index + ADDR_W'(1);
      end

      if (drain_load) begin
        drain_cnt <= DSP_LAT_W'(DSP_LAT);
      end else if (drain_dec && drain_cnt != '0) begin
        drain_cnt <= drain_cnt - DSP_LAT_W'(1);
      end
    end
  end

  assign tap_last   = (tap_index == tap_limit - ADDR_W'(1));
  assign drain_last = (drain_cnt == DSP_LAT_W'(1));

endmodule : mac_tap_counter

// File: rtl/dsp_mac_seq.sv
// Sequencer driving one DSP hard MAC in accumulate mode to compute N-tap
// dot products of streamed operands against RAM-resident coefficients.
//   clk, rst_n           : clock, synchronous active-low reset
//   start                : begin a dot product (sampled in IDLE only)
//   num_taps, coef_base  : tap count and first coefficient address
//   in_valid/in_ready    : operand stream handshake, in_data operand
//   coef_ren, coef_addr  : coefficient RAM read port (1-cycle latency)
//   coef_rdata           : RAM read data
//   dsp_ena, dsp_clr     : DSP ENABLE / CLR
//   dsp_oper, dsp_coef   : DSP OPER_DATA / COEF_DATA
//   dsp_mac_out          : DSP MAC_OUT
//   res_valid/res_ready  : result handshake, res_data captured result
//   busy                 : high whenever the sequencer is not IDLE
module dsp_mac_seq
  import dsp_seq_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int DSP_LAT = DEF_DSP_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_taps,
  input  logic [ADDR_W-1:0] coef_base,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              coef_ren,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [DATA_W-1:0] coef_rdata,
  output logic              dsp_ena,
  output logic              dsp_clr,
  output logic [DATA_W-1:0] dsp_oper,
  output logic [DATA_W-1:0] dsp_coef,
  input  logic [RES_W-1:0]  dsp_mac_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              busy
);

  if (DSP_LAT < DSP_LAT_MIN || DSP_LAT > DSP_LAT_MAX) begin : g_bad_lat
    $error("dsp_mac_seq: DSP_LAT out of range");
  end

  state_t            state;
  logic [ADDR_W-1:0] coef_base_q;
  logic [DATA_W-1:0] oper_q;
  logic [DATA_W-1:0] coef_hold;
  logic [ADDR_W-1:0] tap_index;
  logic              tap_last;
  logic              drain_last;
  logic              accept;
  logic              run_flush;

  assign accept = in_valid & in_ready;

  // in_ready is only ever low in RUN once every tap has been accepted, so
  // that cycle is the final ENABLE cycle and the drain starts after it.
  assign run_flush = (state == ST_RUN) && !in_ready;

  mac_tap_counter #(
    .ADDR_W  (ADDR_W),
    .DSP_LAT (DSP_LAT)
  ) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .tap_load     ((state == ST_IDLE) && start),
    .tap_limit_in (num_taps),
    .tap_inc      (accept),
    .tap_index    (tap_index),
    .tap_last     (tap_last),
    .drain_load   (run_flush),
    .drain_dec    (state == ST_DRAIN),
    .drain_last   (drain_last)
  );

  // The RAM read is issued in the accept cycle itself so its data lines up
  // with the registered operand one cycle later. Address wraps naturally.
  assign coef_ren  = accept;
  assign coef_addr = coef_base_q + tap_index;

  // The RAM data is only meaningful in the ENABLE cycle; afterwards the last
  // coefficient is replayed from a holding register.
  assign dsp_oper = oper_q;
  assign dsp_coef = dsp_ena ? coef_rdata : coef_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      coef_base_q <= '0;
      oper_q      <= '0;
      coef_hold   <= '0;
      in_ready    <= 1'b0;
      dsp_ena     <= 1'b0;
      dsp_clr     <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      busy        <= 1'b0;
    end else begin
      dsp_clr <= 1'b0;
      dsp_ena <= accept;
      if (accept)  oper_q    <= in_data;
      if (dsp_ena) coef_hold <= coef_rdata;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            coef_base_q <= coef_base;
            busy        <= 1'b1;
            if (num_taps == '0) begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              dsp_clr <= 1'b1;
              state   <= ST_CLEAR;
            end
          end
        end

        ST_CLEAR: begin
          in_ready <= 1'b1;
          state    <= ST_RUN;
        end

        ST_RUN: begin
          if (accept && tap_last) in_ready <= 1'b0;
          if (run_flush)          state    <= ST_DRAIN;
        end

        ST_DRAIN: begin
          if (drain_last) begin
            res_data  <= dsp_mac_out;
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          in_ready  <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : dsp_mac_seq
